sdrc_bank_resp: RTL and testbench
=================================

SDRC_BANK_RESP -- requirements
Module: sdrc_bank_resp

Interface
REQ-001 SHALL have parameter APP_RW, default 9, request length width.
REQ-002 SHALL have parameter QDEPTH, default 4, request queue depth, power of two, at least 2.
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 r2b_req  in  1  chunk request from request generator.
REQ-006 r2b_req_id  in  SDR_REQ_ID_W  transfer ID.
REQ-007 r2b_start, r2b_last, r2b_wrap, r2b_write  in  1 each  first chunk / last chunk / wrap mode / write.
REQ-008 r2b_ba  in  2  bank; r2b_raddr  in  12  row; r2b_caddr  in  12  column; r2b_len  in  APP_RW  chunk length.
REQ-009 b2r_ack  out  1  chunk accepted this cycle.
REQ-010 b2r_arb_ok  out  1  room for a new application request.
REQ-011 cfg_trp_d, cfg_trcd_d  in  4 each  precharge and activate wait cycles.
REQ-012 b2x_req  out  1; b2x_cmd  out  2 (00 PRE, 01 ACT, 10 RW); b2x_ba, b2x_raddr, b2x_caddr, b2x_len, b2x_id, b2x_start, b2x_last, b2x_wrap, b2x_write  out  queue-head fields.
REQ-013 x2b_ack  in  1  command accepted; x2b_refresh  in  1  all banks closed; b2x_idle  out  1.

Function
REQ-014 b2r_ack SHALL equal r2b_req & ~full, combinationally, and push the chunk fields into the queue on that edge.
REQ-015 A push when full SHALL NOT occur, even if a pop happens in the same cycle.
REQ-016 Simultaneous push and pop when not full SHALL leave the count unchanged.
REQ-017 b2r_arb_ok SHALL equal (count <= QDEPTH-2).
REQ-018 Per bank, the block SHALL hold an open flag and a 12-bit open row.
REQ-019 The FSM SHALL have the states IDLE, PRE, WAIT_P, ACT, WAIT_A and RW.
REQ-020 From IDLE with the queue non-empty, the next state SHALL be:
  - RW if the head bank is open and its row matches;
  - PRE if the head bank is open with a different row;
  - ACT if the head bank is closed.
REQ-021 In PRE, ACT and RW, b2x_req SHALL be 1, b2x_cmd SHALL be the state's command, and the state SHALL hold until x2b_ack.
REQ-022 On the PRE ack, the block SHALL clear the bank open flag, load timer = cfg_trp_d, and go to WAIT_P.
REQ-023 On the ACT ack, the block SHALL set the open flag and row, load timer = cfg_trcd_d, and go to WAIT_A.
REQ-024 In WAIT_P and WAIT_A the block SHALL decrement the timer and leave when timer==0, so each wait lasts cfg+1 cycles; WAIT_P SHALL exit to ACT and WAIT_A SHALL exit to RW.
REQ-025 On the RW ack, the block SHALL pop the queue head and return to IDLE.
REQ-026 b2x_* fields SHALL always reflect the queue head.
REQ-027 b2x_idle SHALL equal (state==IDLE) & empty.
REQ-028 x2b_refresh SHALL clear all open flags and SHALL be honoured only while b2x_idle=1; it SHALL be ignored otherwise.
REQ-029 Queue pointers SHALL wrap modulo QDEPTH; the count SHALL be clog2(QDEPTH)+1 bits wide.

Reset
REQ-030 On reset:
  - state = IDLE, queue empty, all open flags 0, timer 0;
  - b2x_req 0, b2r_ack 0, b2r_arb_ok 1, b2x_idle 1.
REQ-031 Reset mid-operation SHALL discard all queued chunks and open-row state on the next edge.

Structure
REQ-032 The b2x_cmd encodings and FSM state encodings SHALL live in sdrc_define alongside SDR_REQ_ID_W.
REQ-033 The queue SHALL be a sub-module sdrc_req_queue (data width, depth parameters; push/pop/full/empty/count).
REQ-034 The FSM, bank table and timer SHALL reside in sdrc_bank_resp.

Verification
REQ-035 Single chunk, bank 1, row 0x005, cfg_trcd_d=2, x2b_ack same cycle -> ACT then 3 WAIT_A cycles then RW, one pop, b2x_idle=1 after.
REQ-036 Two chunks to bank 0, rows 0x010 then 0x020, cfg_trp_d=1 -> ACT, RW, PRE, 2 WAIT_P cycles, ACT, RW.
REQ-037 Same-row hit: bank 2 row 0x003 open, new chunk row 0x003 -> IDLE to RW directly, no ACT.
REQ-038 Fill with x2b_ack held 0:
  - 4 pushes; fifth r2b_req gets b2r_ack=0;
  - b2r_arb_ok drops after the third push.
REQ-039 x2b_refresh pulse in idle with bank 3 open -> next chunk to bank 3 same row issues ACT; a pulse while in RW is ignored.
REQ-040 Reset asserted in WAIT_A with 2 queued -> next cycle empty, IDLE, b2x_req=0.

Source files
------------

// File: rtl/sdrc_define.sv
// Shared definitions for the SDRAM bank response block: request ID width,
// command encodings, FSM state encodings and the queued chunk header.
package sdrc_define;

  localparam int SDR_REQ_ID_W = 4;

  localparam logic [1:0] CMD_PRE = 2'b00;
  localparam logic [1:0] CMD_ACT = 2'b01;
  localparam logic [1:0] CMD_RW  = 2'b10;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRE    = 3'd1;
  localparam logic [2:0] ST_WAIT_P = 3'd2;
  localparam logic [2:0] ST_ACT    = 3'd3;
  localparam logic [2:0] ST_WAIT_A = 3'd4;
  localparam logic [2:0] ST_RW     = 3'd5;

  // Chunk fields other than the length, whose width is a block parameter.
  typedef struct packed {
    logic [SDR_REQ_ID_W-1:0] id;
    logic                    start;
    logic                    last;
    logic                    wrap;
    logic                    write;
    logic [1:0]              ba;
    logic [11:0]             raddr;
    logic [11:0]             caddr;
  } chunk_hdr_t;

endpackage

// File: rtl/sdrc_bank_resp_if.sv
// Request-side and command-side signals of the bank response block.
interface sdrc_bank_resp_if
  import sdrc_define::*;
#(
  parameter int APP_RW = 9
) ();

  logic                    r2b_req;
  logic [SDR_REQ_ID_W-1:0] r2b_req_id;
  logic                    r2b_start;
  logic                    r2b_last;
  logic                    r2b_wrap;
  logic                    r2b_write;
  logic [1:0]              r2b_ba;
  logic [11:0]             r2b_raddr;
  logic [11:0]             r2b_caddr;
  logic [APP_RW-1:0]       r2b_len;
  logic                    b2r_ack;
  logic                    b2r_arb_ok;

  logic                    b2x_req;
  logic [1:0]              b2x_cmd;
  logic [1:0]              b2x_ba;
  logic [11:0]             b2x_raddr;
  logic [11:0]             b2x_caddr;
  logic [APP_RW-1:0]       b2x_len;
  logic [SDR_REQ_ID_W-1:0] b2x_id;
  logic                    b2x_start;
  logic                    b2x_last;
  logic                    b2x_wrap;
  logic                    b2x_write;
  logic                    x2b_ack;
  logic                    x2b_refresh;
  logic                    b2x_idle;

  modport slave (
    input  r2b_req, r2b_req_id, r2b_start, r2b_last, r2b_wrap, r2b_write,
           r2b_ba, r2b_raddr, r2b_caddr, r2b_len, x2b_ack, x2b_refresh,
    output b2r_ack, b2r_arb_ok, b2x_req, b2x_cmd, b2x_ba, b2x_raddr,
           b2x_caddr, b2x_len, b2x_id, b2x_start, b2x_last, b2x_wrap,
           b2x_write, b2x_idle
  );

  modport master (
    output r2b_req, r2b_req_id, r2b_start, r2b_last, r2b_wrap, r2b_write,
           r2b_ba, r2b_raddr, r2b_caddr, r2b_len, x2b_ack, x2b_refresh,
    input  b2r_ack, b2r_arb_ok, b2x_req, b2x_cmd, b2x_ba, b2x_raddr,
           b2x_caddr, b2x_len, b2x_id, b2x_start, b2x_last, b2x_wrap,
           b2x_write, b2x_idle
  );

endinterface

// File: rtl/sdrc_req_queue.sv
// Small FIFO of chunk requests; pushes are dropped while full, pops while empty.
module sdrc_req_queue #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full  = (r_count == FULL_CNT);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_mem[r_rd_ptr];

  // A full queue never accepts, even when the head leaves on the same edge.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sdrc_bank_resp.sv
// Per-bank command sequencer: queues chunks, opens/closes rows and issues
// PRE/ACT/RW commands for the queue head with tRP/tRCD waits.
//   state   | meaning
//   IDLE    | waiting for a queued chunk
//   PRE     | precharge requested, waiting for ack
//   WAIT_P  | tRP countdown
//   ACT     | activate requested, waiting for ack
//   WAIT_A  | tRCD countdown
//   RW      | read/write requested, waiting for ack
module sdrc_bank_resp
  import sdrc_define::*;
#(
  parameter int APP_RW = 9,
  parameter int QDEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       cfg_trp_d,
  input  logic [3:0]       cfg_trcd_d,
  sdrc_bank_resp_if.slave  bus
);

  localparam int AW = $clog2(QDEPTH);
  localparam int DW = $bits(chunk_hdr_t) + APP_RW;
  localparam logic [AW:0] ARB_MAX = (AW+1)'(QDEPTH - 2);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [3:0]        r_timer;
  logic [3:0]        r_open;
  logic [11:0]       r_row [4];
  chunk_hdr_t        w_in_hdr;
  chunk_hdr_t        w_hd;
  logic [APP_RW-1:0] w_hd_len;
  logic [DW-1:0]     w_din;
  logic [DW-1:0]     w_dout;
  logic              w_full;
  logic              w_empty;
  logic [AW:0]       w_count;
  logic              w_pop;
  logic              w_hit;
  logic              w_idle;

  always_comb begin
    w_in_hdr       = '0;
    w_in_hdr.id    = bus.r2b_req_id;
    w_in_hdr.start = bus.r2b_start;
    w_in_hdr.last  = bus.r2b_last;
    w_in_hdr.wrap  = bus.r2b_wrap;
    w_in_hdr.write = bus.r2b_write;
    w_in_hdr.ba    = bus.r2b_ba;
    w_in_hdr.raddr = bus.r2b_raddr;
    w_in_hdr.caddr = bus.r2b_caddr;
  end

  assign w_din = {w_in_hdr, bus.r2b_len};
  assign {w_hd, w_hd_len} = w_dout;
  assign w_pop = (r_state == ST_RW) & bus.x2b_ack;

  sdrc_req_queue #(.DW(DW), .DEPTH(QDEPTH)) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (bus.r2b_req),
    .pop   (w_pop),
    .din   (w_din),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign bus.b2r_ack    = bus.r2b_req & ~w_full;
  assign bus.b2r_arb_ok = (w_count <= ARB_MAX);

  assign w_hit  = r_open[w_hd.ba] && (r_row[w_hd.ba] == w_hd.raddr);
  assign w_idle = (r_state == ST_IDLE) & w_empty;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:
        if (!w_empty) begin
          if (w_hit)                 w_state_nxt = ST_RW;
          else if (r_open[w_hd.ba])  w_state_nxt = ST_PRE;
          else                       w_state_nxt = ST_ACT;
        end
      ST_PRE:    if (bus.x2b_ack)       w_state_nxt = ST_WAIT_P;
      ST_WAIT_P: if (r_timer == 4'd0)   w_state_nxt = ST_ACT;
      ST_ACT:    if (bus.x2b_ack)       w_state_nxt = ST_WAIT_A;
      ST_WAIT_A: if (r_timer == 4'd0)   w_state_nxt = ST_RW;
      ST_RW:     if (bus.x2b_ack)       w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_timer <= 4'd0;
      r_open  <= 4'd0;
      for (int i = 0; i < 4; i++) r_row[i] <= 12'd0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        ST_PRE:
          if (bus.x2b_ack) begin
            r_open[w_hd.ba] <= 1'b0;
            r_timer         <= cfg_trp_d;
          end
        ST_ACT:
          if (bus.x2b_ack) begin
            r_open[w_hd.ba] <= 1'b1;
            r_row[w_hd.ba]  <= w_hd.raddr;
            r_timer         <= cfg_trcd_d;
          end
        ST_WAIT_P, ST_WAIT_A:
          if (r_timer != 4'd0) r_timer <= r_timer - 4'd1;
        default: ;
      endcase
      // Refresh closes every bank, but only when nothing is in flight.
      if (w_idle && bus.x2b_refresh) r_open <= 4'd0;
    end
  end

  always_comb begin
    bus.b2x_cmd = CMD_PRE;
    case (r_state)
      ST_ACT:  bus.b2x_cmd = CMD_ACT;
      ST_RW:   bus.b2x_cmd = CMD_RW;
      default: bus.b2x_cmd = CMD_PRE;
    endcase
  end

  assign bus.b2x_req   = (r_state == ST_PRE) | (r_state == ST_ACT) | (r_state == ST_RW);
  assign bus.b2x_idle  = w_idle;
  assign bus.b2x_ba    = w_hd.ba;
  assign bus.b2x_raddr = w_hd.raddr;
  assign bus.b2x_caddr = w_hd.caddr;
  assign bus.b2x_len   = w_hd_len;
  assign bus.b2x_id    = w_hd.id;
  assign bus.b2x_start = w_hd.start;
  assign bus.b2x_last  = w_hd.last;
  assign bus.b2x_wrap  = w_hd.wrap;
  assign bus.b2x_write = w_hd.write;

endmodule

// File: tb/tb_sdrc_bank_resp.sv
// Scoreboard bench: directed chunks queue their expected command sequence,
// a monitor checks every accepted command (fields and cycle spacing).
module tb_sdrc_bank_resp;
  import sdrc_define::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] cfg_trp_d;
  logic [3:0] cfg_trcd_d;

  sdrc_bank_resp_if #(.APP_RW(9)) bus ();

  sdrc_bank_resp #(.APP_RW(9), .QDEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_trp_d  (cfg_trp_d),
    .cfg_trcd_d (cfg_trcd_d),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  cmd;
    logic [1:0]  ba;
    logic [11:0] raddr;
    logic [11:0] caddr;
    int          gap;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   last_cyc = 0;
  int   mgap;
  logic mok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic expect_cmd(input logic [1:0] cmd, input logic [1:0] ba,
                            input logic [11:0] row, input logic [11:0] col, input int gap);
    sb.push_back('{cmd, ba, row, col, gap});
  endtask

  // Starts just after a falling edge, returns on the next falling edge.
  task automatic push(input logic [1:0] ba, input logic [11:0] row,
                      input logic [11:0] col, input logic exp_ack);
    bus.r2b_req    = 1'b1;
    bus.r2b_ba     = ba;
    bus.r2b_raddr  = row;
    bus.r2b_caddr  = col;
    bus.r2b_len    = 9'd8;
    bus.r2b_req_id = col[3:0];
    bus.r2b_start  = 1'b1;
    bus.r2b_last   = 1'b1;
    bus.r2b_wrap   = 1'b0;
    bus.r2b_write  = col[0];
    #1 check("b2r_ack", 32'(bus.b2r_ack), 32'(exp_ack));
    @(negedge clk);
    bus.r2b_req = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(bus.b2x_idle && sb.size() == 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.b2x_idle), 32'd1);
    check({name, "_sb"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_refresh();
    bus.x2b_refresh = 1'b1;
    @(negedge clk);
    bus.x2b_refresh = 1'b0;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!reset && bus.b2x_req && bus.x2b_ack) begin
        total++;
        mgap = cyc - last_cyc;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_cmd: got cmd=%0d ba=%0d row=%h col=%h required none",
                   bus.b2x_cmd, bus.b2x_ba, bus.b2x_raddr, bus.b2x_caddr);
        end else begin
          me = sb.pop_front();
          mok = (bus.b2x_cmd == me.cmd) && (bus.b2x_ba == me.ba) &&
                (bus.b2x_raddr == me.raddr) &&
                ((me.cmd != CMD_RW) || (bus.b2x_caddr == me.caddr)) &&
                ((me.gap < 0) || (mgap == me.gap));
          if (!mok) begin
            bad++;
            $display("FAIL sb_cmd: got cmd=%0d ba=%0d row=%h col=%h gap=%0d required cmd=%0d ba=%0d row=%h col=%h gap=%0d",
                     bus.b2x_cmd, bus.b2x_ba, bus.b2x_raddr, bus.b2x_caddr, mgap,
                     me.cmd, me.ba, me.raddr, me.caddr, me.gap);
          end
        end
        last_cyc = cyc;
      end
    end
  end

  initial begin
    reset           = 1'b1;
    cfg_trp_d       = 4'd1;
    cfg_trcd_d      = 4'd2;
    bus.r2b_req     = 1'b0;
    bus.r2b_req_id  = '0;
    bus.r2b_start   = 1'b0;
    bus.r2b_last    = 1'b0;
    bus.r2b_wrap    = 1'b0;
    bus.r2b_write   = 1'b0;
    bus.r2b_ba      = 2'd0;
    bus.r2b_raddr   = 12'd0;
    bus.r2b_caddr   = 12'd0;
    bus.r2b_len     = 9'd0;
    bus.x2b_ack     = 1'b0;
    bus.x2b_refresh = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_b2x_req", 32'(bus.b2x_req), 32'd0);
    check("rst_b2r_ack", 32'(bus.b2r_ack), 32'd0);
    check("rst_arb_ok", 32'(bus.b2r_arb_ok), 32'd1);
    check("rst_idle", 32'(bus.b2x_idle), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    bus.x2b_ack = 1'b1;
    @(negedge clk);

    // Single chunk to a closed bank: ACT, 3 tRCD cycles, RW.
    expect_cmd(CMD_ACT, 2'd1, 12'h005, 12'h000, -1);
    expect_cmd(CMD_RW,  2'd1, 12'h005, 12'h011, 4);
    push(2'd1, 12'h005, 12'h011, 1'b1);
    wait_idle("t1_idle");

    // Row miss on bank 0: ACT, RW, PRE, 2 tRP cycles, ACT, RW.
    expect_cmd(CMD_ACT, 2'd0, 12'h010, 12'h000, -1);
    expect_cmd(CMD_RW,  2'd0, 12'h010, 12'h021, 4);
    expect_cmd(CMD_PRE, 2'd0, 12'h020, 12'h000, 2);
    expect_cmd(CMD_ACT, 2'd0, 12'h020, 12'h000, 3);
    expect_cmd(CMD_RW,  2'd0, 12'h020, 12'h022, 4);
    push(2'd0, 12'h010, 12'h021, 1'b1);
    push(2'd0, 12'h020, 12'h022, 1'b1);
    wait_idle("t2_idle");

    // Row hit goes straight to RW.
    expect_cmd(CMD_ACT, 2'd2, 12'h003, 12'h000, -1);
    expect_cmd(CMD_RW,  2'd2, 12'h003, 12'h031, 4);
    push(2'd2, 12'h003, 12'h031, 1'b1);
    wait_idle("t3a_idle");
    expect_cmd(CMD_RW,  2'd2, 12'h003, 12'h032, -1);
    push(2'd2, 12'h003, 12'h032, 1'b1);
    wait_idle("t3b_idle");

    // Fill with commands stalled; fifth request refused.
    bus.x2b_ack = 1'b0;
    expect_cmd(CMD_RW, 2'd1, 12'h005, 12'h041, -1);
    expect_cmd(CMD_RW, 2'd1, 12'h005, 12'h042, 2);
    expect_cmd(CMD_RW, 2'd1, 12'h005, 12'h043, 2);
    expect_cmd(CMD_RW, 2'd1, 12'h005, 12'h044, 2);
    push(2'd1, 12'h005, 12'h041, 1'b1);
    #1 check("arb_ok_1", 32'(bus.b2r_arb_ok), 32'd1);
    push(2'd1, 12'h005, 12'h042, 1'b1);
    #1 check("arb_ok_2", 32'(bus.b2r_arb_ok), 32'd1);
    push(2'd1, 12'h005, 12'h043, 1'b1);
    #1 check("arb_ok_3", 32'(bus.b2r_arb_ok), 32'd0);
    push(2'd1, 12'h005, 12'h044, 1'b1);
    #1 check("arb_ok_4", 32'(bus.b2r_arb_ok), 32'd0);
    push(2'd1, 12'h005, 12'h045, 1'b0);
    #1 check("arb_ok_full", 32'(bus.b2r_arb_ok), 32'd0);
    @(negedge clk);
    bus.x2b_ack = 1'b1;
    wait_idle("t4_idle");

    // Refresh in idle closes bank 3; a refresh during RW is ignored.
    expect_cmd(CMD_ACT, 2'd3, 12'h007, 12'h000, -1);
    expect_cmd(CMD_RW,  2'd3, 12'h007, 12'h051, 4);
    push(2'd3, 12'h007, 12'h051, 1'b1);
    wait_idle("t5a_idle");
    pulse_refresh();
    expect_cmd(CMD_ACT, 2'd3, 12'h007, 12'h000, -1);
    expect_cmd(CMD_RW,  2'd3, 12'h007, 12'h052, 4);
    push(2'd3, 12'h007, 12'h052, 1'b1);
    wait_idle("t5b_idle");
    bus.x2b_ack = 1'b0;
    expect_cmd(CMD_RW, 2'd3, 12'h007, 12'h053, -1);
    push(2'd3, 12'h007, 12'h053, 1'b1);
    @(negedge clk);
    #1 check("t5_in_rw", 32'(bus.b2x_cmd), 32'(CMD_RW));
    pulse_refresh();
    bus.x2b_ack = 1'b1;
    wait_idle("t5c_idle");
    expect_cmd(CMD_RW, 2'd3, 12'h007, 12'h054, -1);
    push(2'd3, 12'h007, 12'h054, 1'b1);
    wait_idle("t5d_idle");

    // Reset during tRCD with two chunks queued.
    pulse_refresh();
    expect_cmd(CMD_ACT, 2'd2, 12'h009, 12'h000, -1);
    push(2'd2, 12'h009, 12'h061, 1'b1);
    push(2'd2, 12'h009, 12'h062, 1'b1);
    @(negedge clk);
    #1 check("t6_wait_a_req", 32'(bus.b2x_req), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("t6_rst_idle", 32'(bus.b2x_idle), 32'd1);
    check("t6_rst_req", 32'(bus.b2x_req), 32'd0);
    check("t6_rst_arb_ok", 32'(bus.b2r_arb_ok), 32'd1);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_still_idle", 32'(bus.b2x_idle), 32'd1);
    expect_cmd(CMD_ACT, 2'd1, 12'h005, 12'h000, -1);
    expect_cmd(CMD_RW,  2'd1, 12'h005, 12'h071, 4);
    push(2'd1, 12'h005, 12'h071, 1'b1);
    wait_idle("t6_idle");

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
